// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Single-word read/write sequencer that sits in front of a synchronous-read
//   word RAM. It accepts one request at a time over a valid/ready handshake,
//   latches the address (MAR) and write data, and strobes the RAM for exactly
//   one cycle. Read data is captured into the MDR after the RAM's registered
//   output latency. Completion is signalled with a one-cycle response pulse.
//
// Ports
//   clock        : system clock, all state changes on posedge
//   clear        : synchronous active-low reset
//   req_valid    : request present
//   req_ready    : high only while idle (request can be accepted)
//   req_write    : 1 = write, 0 = read (sampled on accept)
//   req_addr     : 32-bit word address, low ADDR_W bits used (sampled on accept)
//   req_wdata    : write data (sampled on accept)
//   resp_valid   : one-cycle completion pulse
//   resp_rdata   : MDR contents
//   resp_err     : out-of-range flag, meaningful with resp_valid
//   mem_read     : RAM read strobe
//   mem_write    : RAM write strobe
//   mem_address  : RAM address (always the MAR)
//   mem_data_in  : RAM write data (always the latched write data)
//   mem_data_out : RAM registered read data
//
// Build option
//   MEM_BOUNDS_CHECK_EN : when defined, requests with non-zero address bits
//                         above ADDR_W complete immediately with resp_err=1
//                         and never touch the RAM. When undefined those bits
//                         are ignored and resp_err is always 0.

module mem_access_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  // The wait counter only has to hold RD_LATENCY-1.
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mdr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              write_flag;
  logic              err_q;
  logic              out_of_range;

`ifdef MEM_BOUNDS_CHECK_EN
  assign out_of_range = |req_addr[31:ADDR_W];
`else
  // Upper address bits are deliberately dropped in this build.
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr[31:ADDR_W];
  assign out_of_range   = 1'b0;
`endif

  // State register plus the datapath registers. Each register is only
  // loaded in the one state that owns it, so everything else simply holds.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state      <= IDLE;
      mar        <= '0;
      wdata_q    <= '0;
      mdr        <= '0;
      wait_cnt   <= '0;
      write_flag <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mar        <= req_addr[ADDR_W-1:0];
            wdata_q    <= req_wdata;
            write_flag <= req_write;
            err_q      <= out_of_range;
          end
        end
        ISSUE:   wait_cnt <= WAIT_LOAD;
        WAIT:    wait_cnt <= wait_cnt - CNT_W'(1);
        CAPTURE: mdr      <= mem_data_out;
        default: ;
      endcase
    end
  end

  // Next-state decode. In WAIT the counter is decremented this cycle, so
  // seeing 1 here means it reaches 0 at the edge and we move to CAPTURE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = out_of_range ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (write_flag) begin
          state_next = RESP;
        end else if (RD_LATENCY > 1) begin
          state_next = WAIT;
        end else begin
          state_next = CAPTURE;
        end
      end
      WAIT: begin
        if (wait_cnt <= CNT_W'(1)) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend on registered state only, never on request inputs, so
  // the RAM strobes are glitch-free and read/write can never overlap.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = mar;
    mem_data_in = wdata_q;
    resp_rdata  = mdr;
    case (state)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        mem_write = write_flag;
        mem_read  = ~write_flag;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Self-checking bench for mem_access_ctrl. A behavioural 512x32 RAM with a
//   one-cycle registered read port is attached to the memory side. Requests
//   come from a table of {request, expected response} records; each accepted
//   request is pushed to a scoreboard queue and checked when its RAM strobe
//   and its response pulse appear. Reset and mid-operation clear are covered
//   by hand-written sequences.

module tb_mem_access_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LAT    = 1;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic              clock;
  logic              clear;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  mem_access_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LATENCY(LAT)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Clock: posedges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural RAM with a single registered read stage.
  logic [31:0] ram [512];
  logic [31:0] ram_q;
  assign mem_data_out = ram_q;

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'hC0DE_0000 | i;
    ram_q = '0;
  end

  always @(posedge clock) begin
    if (mem_write) ram[mem_address] <= mem_data_in;
    if (mem_read)  ram_q <= ram[mem_address];
  end

  // Scoreboard bookkeeping.
  typedef struct {
    logic        write;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          t;
  } sb_t;

  sb_t         sb_q[$];
  int          cycle = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cur_exp_rdata = '0;
  logic        cur_exp_err = 1'b0;

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  task automatic noteFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: event at cycle %0d not expected", name, cycle);
  endtask

  // An accepting edge pushes the expected outcome; cycle then advances so
  // that the ISSUE cycle reads as t+1.
  always @(posedge clock) begin
    sb_t e;
    if (clear === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1) begin
      e.write     = req_write;
      e.addr      = req_addr[8:0];
      e.wdata     = req_wdata;
      e.exp_rdata = cur_exp_rdata;
      e.exp_err   = cur_exp_err;
      e.t         = cycle;
      sb_q.push_back(e);
    end
    cycle = cycle + 1;
  end

  // Per-cycle monitor, sampled on the falling edge.
  task automatic checkOutput();
    sb_t e;
    int  lat;
    if (clear !== 1'b1) return;
    checkVal("req_ready", {31'b0, req_ready}, {31'b0, (sb_q.size() == 0)});
    checkVal("strobe_overlap", {31'b0, mem_read & mem_write}, 32'd0);
    if (mem_read || mem_write) begin
      if (sb_q.size() == 0) begin
        noteFail("strobe_unexpected");
      end else begin
        e = sb_q[0];
        checkVal("strobe_kind", {31'b0, mem_write}, {31'b0, e.write});
        checkVal("mem_address", {23'b0, mem_address}, {23'b0, e.addr});
        if (e.write) checkVal("mem_data_in", mem_data_in, e.wdata);
        checkVal("strobe_cycle", cycle, e.t + 1);
      end
    end
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        noteFail("resp_unexpected");
      end else begin
        e   = sb_q.pop_front();
        lat = e.exp_err ? 1 : (e.write ? 2 : 2 + LAT);
        checkVal("resp_rdata", resp_rdata, e.exp_rdata);
        checkVal("resp_err", {31'b0, resp_err}, {31'b0, e.exp_err});
        checkVal("resp_cycle", cycle, e.t + lat);
      end
    end
  endtask

  always @(negedge clock) checkOutput();

  // Present a request and wait (bounded) until it is accepted. Returns at the
  // falling edge after the accepting edge with req_valid still high.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_r, input logic exp_e);
    bit done = 1'b0;
    req_write     = w;
    req_addr      = a;
    req_wdata     = d;
    cur_exp_rdata = exp_r;
    cur_exp_err   = exp_e;
    req_valid     = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (req_ready === 1'b1) begin
        @(posedge clock);
        @(negedge clock);
        done = 1'b1;
      end else begin
        @(negedge clock);
      end
    end
    if (!done) noteFail("accept_timeout");
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (sb_q.size() == 0) done = 1'b1;
      else @(negedge clock);
    end
    if (!done) noteFail("drain_timeout");
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Expected rdata is always the MDR: writes report the last read value.
    vecs[0] = '{1'b1, 32'h0000_0095, 32'h0000_0022, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0095, 32'h0000_0000, 32'h0000_0022, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_01FF, 32'hDEAD_BEEF, 32'h0000_0022, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_01FF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hC0DE_0010, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'hC0DE_0010, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0200, 32'h0000_0000,
                BOUNDS ? 32'hC0DE_0010 : 32'h1234_5678, BOUNDS};
    vecs[7] = '{1'b0, 32'hFFFF_FE95, 32'h0000_0000,
                BOUNDS ? 32'hC0DE_0010 : 32'h0000_0022, BOUNDS};
    vecs[8] = '{1'b1, 32'h0000_00AA, 32'hA5A5_A5A5,
                BOUNDS ? 32'hC0DE_0010 : 32'h0000_0022, 1'b0};
    vecs[9] = '{1'b0, 32'h0000_00AA, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};

    clear     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset held for two edges.
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkVal("rst_req_ready",   {31'b0, req_ready},  32'd1);
    checkVal("rst_resp_valid",  {31'b0, resp_valid}, 32'd0);
    checkVal("rst_resp_err",    {31'b0, resp_err},   32'd0);
    checkVal("rst_mem_read",    {31'b0, mem_read},   32'd0);
    checkVal("rst_mem_write",   {31'b0, mem_write},  32'd0);
    checkVal("rst_mem_address", {23'b0, mem_address}, 32'd0);
    checkVal("rst_mem_data_in", mem_data_in, 32'd0);
    checkVal("rst_resp_rdata",  resp_rdata,  32'd0);
    clear = 1'b1;
    @(negedge clock);
    checkVal("idle_req_ready",  {31'b0, req_ready},  32'd1);
    checkVal("idle_resp_valid", {31'b0, resp_valid}, 32'd0);

    // Table: req_valid stays high across vectors, so acceptance relies on
    // the controller dropping req_ready while busy.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err);
    end
    req_valid = 1'b0;
    waitDrain();

    // Read interrupted by clear in its CAPTURE cycle: no response, MDR wiped.
    applyStimulus(1'b0, 32'h0000_00AA, 32'h0, 32'hA5A5_A5A5, 1'b0);
    req_valid = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    sb_q.delete();
    @(negedge clock);
    checkVal("intr_req_ready",  {31'b0, req_ready},  32'd1);
    checkVal("intr_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkVal("intr_resp_rdata", resp_rdata, 32'd0);
    checkVal("intr_mem_read",   {31'b0, mem_read},   32'd0);
    clear = 1'b1;
    repeat (3) @(negedge clock);
    checkVal("intr_mdr_kept_zero", resp_rdata, 32'd0);

    // Write interrupted right after ISSUE: the RAM write still lands.
    applyStimulus(1'b1, 32'h0000_0050, 32'h0000_0055, 32'h0, 1'b0);
    req_valid = 1'b0;
    clear = 1'b0;
    sb_q.delete();
    @(negedge clock);
    checkVal("intw_resp_valid", {31'b0, resp_valid}, 32'd0);
    clear = 1'b1;
    @(negedge clock);
    applyStimulus(1'b0, 32'h0000_0050, 32'h0, 32'h0000_0055, 1'b0);
    req_valid = 1'b0;
    waitDrain();
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
